hack_ctrl: RTL and testbench
============================

HACK_CTRL -- requirements
Module: hack_ctrl

Interface
REQ-001 The block SHALL have one clock, clk, and reset, reset, which is asynchronous and active-high; port order SHALL be clk, reset, then the rest.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 instr_valid  input  1  instruction memory presents a valid word.
REQ-005 instruction  input  16  Hack instruction word.
REQ-006 instr_ready  output  1  controller accepts an instruction this cycle.
REQ-007 alu_zr, alu_ng  input  1 each  ALU zero and negative flags.
REQ-008 mem_ready  input  1  data memory write acknowledge.
REQ-009 zx, nx, zy, ny, f, no  output  1 each  ALU control bits.
REQ-010 sel_am  output  1  ALU y operand source: 0 = A, 1 = M.
REQ-011 a_src_instr  output  1  A register source: 1 = instruction, 0 = ALU out.
REQ-012 load_a, load_d, write_m  output  1 each  register and memory write strobes.
REQ-013 pc_load, pc_inc  output  1 each  PC jump-load and increment strobes; never both 1.
REQ-014 instret  output  16  retired-instruction counter.

Function
REQ-015 The FSM SHALL have three states, FETCH, EXEC and WB, and SHALL leave reset in FETCH.
REQ-016 FETCH SHALL drive instr_ready=1 and all strobes 0; on instr_valid=1 it SHALL latch instruction into ir and go to EXEC.
REQ-017 EXEC with ir[15]=0 (A-instr) SHALL pulse load_a=1, a_src_instr=1 and pc_inc=1 for one cycle, increment instret, then go to FETCH.
REQ-018 EXEC with ir[15]=1 (C-instr) SHALL drive {zx,nx,zy,ny,f,no}=ir[11:6] and sel_am=ir[12], latch alu_zr/alu_ng into flag registers, drive all strobes 0, then go to WB.
REQ-019 WB SHALL hold the ALU controls and sel_am from EXEC and drive a_src_instr=0.
REQ-020 WB SHALL drive write_m=ir[3] on every WB cycle.
REQ-021 The WB completion condition done is (ir[3]=0) or mem_ready.
REQ-022 WB SHALL drive load_a=ir[5], load_d=ir[4], pc_load=jump and pc_inc=!jump only in the cycle where done=1; it SHALL drive them 0 otherwise.
REQ-023 jump SHALL be (ir[2] and ng_q) or (ir[1] and zr_q) or (ir[0] and !zr_q and !ng_q), using the flags latched in EXEC.
REQ-024 While done=0, WB SHALL remain in WB with no limit on wait cycles; when done=1 it SHALL increment instret and go to FETCH.
REQ-025 ir[14:13] SHALL be ignored; outside C-instr EXEC and WB, the ALU controls and sel_am SHALL be 0.
REQ-026 instret SHALL wrap from 0xFFFF to 0x0000.
REQ-027 Latency SHALL be 2 cycles per A-instr and 3+N cycles per C-instr, where N is the number of mem_ready wait cycles, with instruction accepted on the first cycle.

Reset
REQ-028 While reset=1, the block SHALL hold state=FETCH, ir=0, flags=0 and instret=0, with all outputs 0 including instr_ready, regardless of clk.
REQ-029 Reset asserted mid-instruction (EXEC or WB, including a pending write) SHALL abort it at once, with no strobe and no instret increment.

Structure
REQ-030 The state encoding and instruction field positions (a=12, comp=11:6, dest=5:3, jump=2:0) SHALL live in the shared package hack_pkg.
REQ-031 Jump evaluation SHALL be a separate combinational sub-module, hack_jump_unit (inputs j[2:0], zr, ng; output jump).

Verification
REQ-032 The bench SHALL cover: 0x0005 accepted -> next cycle load_a=1, a_src_instr=1, pc_inc=1; FETCH on cycle 3; instret +1.
REQ-033 The bench SHALL cover: 0xEC10 (D=A) -> EXEC ctrl=110000, sel_am=0; WB load_d=1, pc_inc=1, write_m=0.
REQ-034 The bench SHALL cover: 0xEA87 (0;JMP) with zr=1 -> WB pc_load=1, pc_inc=0.
REQ-035 The bench SHALL cover: 0xE301 (D;JGT) -> with zr=1, ng=0, pc_inc=1; with zr=0, ng=0, pc_load=1; with ng=1, pc_inc=1.
REQ-036 The bench SHALL cover: 0xE7C8 (M=D+1) with mem_ready low 3 cycles -> write_m high 4 cycles, a single pc_inc pulse in the ack cycle, instret +1 once.
REQ-037 The bench SHALL cover: reset pulsed in WB while waiting on mem_ready -> write_m falls without waiting for a clock edge, instret=0, and FETCH with instr_ready=1 on the first edge after release.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared types, widths and Hack instruction field positions for the controller.
package hack_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned JUMP_W  = 3;

    // Instruction field positions
    localparam int unsigned BIT_CI  = 15;
    localparam int unsigned BIT_A   = 12;
    localparam int unsigned COMP_HI = 11;
    localparam int unsigned COMP_LO = 6;
    localparam int unsigned DEST_A  = 5;
    localparam int unsigned DEST_D  = 4;
    localparam int unsigned DEST_M  = 3;
    localparam int unsigned JUMP_HI = 2;
    localparam int unsigned JUMP_LO = 0;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_WB    = 2'd2
    } state_e;

    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_t;

    // Extract the ALU control bits from a C-instruction.
    function automatic alu_ctrl_t comp_field(input logic [INSTR_W-1:0] ins);
        return alu_ctrl_t'(ins[COMP_HI:COMP_LO]);
    endfunction

endpackage

// File: rtl/hack_ctrl_if.sv
// Controller <-> instruction memory / ALU / data memory signal bundle.
interface hack_ctrl_if;
    import hack_pkg::*;

    logic               instr_valid;
    logic [INSTR_W-1:0] instruction;
    logic               instr_ready;
    logic               alu_zr;
    logic               alu_ng;
    logic               mem_ready;
    logic               zx;
    logic               nx;
    logic               zy;
    logic               ny;
    logic               f;
    logic               no;
    logic               sel_am;
    logic               a_src_instr;
    logic               load_a;
    logic               load_d;
    logic               write_m;
    logic               pc_load;
    logic               pc_inc;
    logic [CNT_W-1:0]   instret;

    // Controller side
    modport master (
        input  instr_valid, instruction, alu_zr, alu_ng, mem_ready,
        output instr_ready, zx, nx, zy, ny, f, no, sel_am, a_src_instr,
               load_a, load_d, write_m, pc_load, pc_inc, instret
    );

    // Datapath / memory side
    modport slave (
        output instr_valid, instruction, alu_zr, alu_ng, mem_ready,
        input  instr_ready, zx, nx, zy, ny, f, no, sel_am, a_src_instr,
               load_a, load_d, write_m, pc_load, pc_inc, instret
    );

endinterface

// File: rtl/hack_jump_unit.sv
// Combinational jump decision from the jump field and latched ALU flags.
module hack_jump_unit
    import hack_pkg::*;
(
    input  logic [JUMP_W-1:0] j,
    input  logic              zr,
    input  logic              ng,
    output logic              jump
);

    // j[2]=less than zero, j[1]=equal zero, j[0]=greater than zero
    assign jump = (j[2] & ng) | (j[1] & zr) | (j[0] & ~zr & ~ng);

endmodule

// File: rtl/hack_ctrl.sv
// Hack CPU control unit: FETCH -> EXEC -> (WB) sequencing with memory-write handshake.
module hack_ctrl
    import hack_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    hack_ctrl_if.master bus
);

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               zr_q, zr_d;
    logic               ng_q, ng_d;
    logic [CNT_W-1:0]   instret_q, instret_d;

    logic               is_c_c;
    logic               done_c;
    logic               jump_c;
    logic               retire_c;
    alu_ctrl_t          ctrl_c;
    logic               unused_ir_bits;

    assign is_c_c   = ir_q[BIT_CI];
    assign done_c   = ~ir_q[DEST_M] | bus.mem_ready;
    assign ctrl_c   = comp_field(ir_q);
    assign retire_c = ((state_q == ST_EXEC) && !is_c_c) || ((state_q == ST_WB) && done_c);

    // ir[14:13] carry no meaning for this controller
    assign unused_ir_bits = ^ir_q[14:13];

    hack_jump_unit u_jump (
        .j    (ir_q[JUMP_HI:JUMP_LO]),
        .zr   (zr_q),
        .ng   (ng_q),
        .jump (jump_c)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: if (bus.instr_valid) state_d = ST_EXEC;
            ST_EXEC:  state_d = is_c_c ? ST_WB : ST_FETCH;
            ST_WB:    if (done_c) state_d = ST_FETCH;
            default:  state_d = ST_FETCH;
        endcase
    end

    // Datapath next values: instruction latch, flag capture, retire counter
    always_comb begin
        ir_d      = ir_q;
        zr_d      = zr_q;
        ng_d      = ng_q;
        instret_d = instret_q;
        if ((state_q == ST_FETCH) && bus.instr_valid) begin
            ir_d = bus.instruction;
        end
        if ((state_q == ST_EXEC) && is_c_c) begin
            zr_d = bus.alu_zr;
            ng_d = bus.alu_ng;
        end
        if (retire_c) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q      <= '0;
            zr_q      <= 1'b0;
            ng_q      <= 1'b0;
            instret_q <= '0;
        end else begin
            ir_q      <= ir_d;
            zr_q      <= zr_d;
            ng_q      <= ng_d;
            instret_q <= instret_d;
        end
    end

    assign bus.instret = instret_q;

    // Output decode; reset forces every control output low immediately
    always_comb begin
        bus.instr_ready = 1'b0;
        bus.zx          = 1'b0;
        bus.nx          = 1'b0;
        bus.zy          = 1'b0;
        bus.ny          = 1'b0;
        bus.f           = 1'b0;
        bus.no          = 1'b0;
        bus.sel_am      = 1'b0;
        bus.a_src_instr = 1'b0;
        bus.load_a      = 1'b0;
        bus.load_d      = 1'b0;
        bus.write_m     = 1'b0;
        bus.pc_load     = 1'b0;
        bus.pc_inc      = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    bus.instr_ready = 1'b1;
                end
                ST_EXEC: begin
                    if (!is_c_c) begin
                        bus.load_a      = 1'b1;
                        bus.a_src_instr = 1'b1;
                        bus.pc_inc      = 1'b1;
                    end else begin
                        {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = ctrl_c;
                        bus.sel_am = ir_q[BIT_A];
                    end
                end
                ST_WB: begin
                    {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = ctrl_c;
                    bus.sel_am  = ir_q[BIT_A];
                    bus.write_m = ir_q[DEST_M];
                    if (done_c) begin
                        bus.load_a  = ir_q[DEST_A];
                        bus.load_d  = ir_q[DEST_D];
                        bus.pc_load = jump_c;
                        bus.pc_inc  = ~jump_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hack_ctrl.sv
// Self-checking bench for hack_ctrl: directed Hack instructions plus random traffic.
module tb_hack_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    int          n_chk = 0;
    int          n_bad = 0;
    logic [15:0] instret_m = 16'h0;

    hack_ctrl_if bus ();

    hack_ctrl u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // {ready, zx,nx,zy,ny,f,no, sel_am, a_src, load_a, load_d, write_m, pc_load, pc_inc}
    function automatic logic [13:0] obs();
        return {bus.instr_ready, bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no,
                bus.sel_am, bus.a_src_instr, bus.load_a, bus.load_d, bus.write_m,
                bus.pc_load, bus.pc_inc};
    endfunction

    function automatic logic [13:0] mk(input logic rdy, input logic [5:0] ctrl, input logic sel,
                                       input logic asrc, input logic la, input logic ld,
                                       input logic wm, input logic pl, input logic pi);
        return {rdy, ctrl, sel, asrc, la, ld, wm, pl, pi};
    endfunction

    // Hack jump semantics: choose the bit matching the sign of the ALU result
    function automatic logic model_jump(input logic [2:0] j, input logic zr, input logic ng);
        if (ng)      return j[2];
        else if (zr) return j[1];
        else         return j[0];
    endfunction

    task automatic sample(input string tag, input logic [13:0] exp);
        #1;
        chk(tag, 32'(obs()), 32'(exp));
        chk({tag, "_instret"}, 32'(bus.instret), 32'(instret_m));
    endtask

    // Issue one instruction and check every cycle until it retires.
    // zr/ng: flags presented in EXEC (a consistent pair); waits: mem_ready low cycles for M writes.
    task automatic run_instr(input logic [15:0] ins, input logic zr, input logic ng, input int waits);
        logic [5:0] ctrl;
        logic       jmp;
        logic       done;
        int         idle;
        ctrl = ins[11:6];
        idle = int'($urandom_range(0, 2));
        for (int i = 0; i < idle; i++) begin
            @(negedge clk);
            bus.instr_valid = 1'b0;
            bus.instruction = 16'($urandom);
            bus.mem_ready   = 1'($urandom);
            sample("fetch_idle", mk(1'b1, 6'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instruction = ins;
        sample("fetch", mk(1'b1, 6'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        bus.instr_valid = 1'($urandom);
        bus.instruction = 16'($urandom);
        bus.alu_zr      = zr;
        bus.alu_ng      = ng;
        if (!ins[15]) begin
            sample("exec_a", mk(1'b0, 6'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
            instret_m = instret_m + 16'h1;
            return;
        end
        sample("exec_c", mk(1'b0, ctrl, ins[12], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        jmp = model_jump(ins[2:0], zr, ng);
        for (int k = 0; k <= waits; k++) begin
            @(negedge clk);
            bus.alu_zr    = 1'($urandom);
            bus.alu_ng    = 1'($urandom);
            bus.mem_ready = ins[3] ? (k >= waits) : 1'($urandom);
            done = !ins[3] || (k >= waits);
            if (done) begin
                sample("wb_done", mk(1'b0, ctrl, ins[12], 1'b0, ins[5], ins[4], ins[3], jmp, !jmp));
                instret_m = instret_m + 16'h1;
                break;
            end
            sample("wb_wait", mk(1'b0, ctrl, ins[12], 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        end
    endtask

    initial begin
        logic [15:0] ins;
        int          fl;
        reset           = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instruction = 16'h0;
        bus.alu_zr      = 1'b0;
        bus.alu_ng      = 1'b0;
        bus.mem_ready   = 1'b0;

        #2;
        chk("rst_outputs", 32'(obs()), 32'h0);
        chk("rst_instret", 32'(bus.instret), 32'h0);
        @(negedge clk);
        bus.instr_valid = 1'b1;
        #1;
        chk("rst_hold", 32'(obs()), 32'h0);
        reset = 1'b0;
        bus.instr_valid = 1'b0;

        // Directed cases
        run_instr(16'h0005, 1'b0, 1'b0, 0);
        run_instr(16'hEC10, 1'b0, 1'b0, 0);
        run_instr(16'hEA87, 1'b1, 1'b0, 0);
        run_instr(16'hE301, 1'b1, 1'b0, 0);
        run_instr(16'hE301, 1'b0, 1'b0, 0);
        run_instr(16'hE301, 1'b0, 1'b1, 0);
        run_instr(16'hE7C8, 1'b0, 1'b0, 3);

        // Reset while a memory write is pending in WB
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instruction = 16'hE7C8;
        sample("rw_fetch", mk(1'b1, 6'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        bus.instr_valid = 1'b0;
        sample("rw_exec", mk(1'b0, 6'b011111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        bus.mem_ready = 1'b0;
        sample("rw_wait", mk(1'b0, 6'b011111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        #1;
        reset = 1'b1;
        instret_m = 16'h0;
        #1;
        chk("rw_async_out", 32'(obs()), 32'h0);
        chk("rw_async_instret", 32'(bus.instret), 32'h0);
        @(negedge clk);
        bus.mem_ready = 1'b1;
        #1;
        chk("rw_hold", 32'(obs()), 32'h0);
        reset = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        sample("rw_release", mk(1'b1, 6'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            ins = 16'($urandom);
            fl  = int'($urandom_range(0, 2));
            run_instr(ins, fl == 1, fl == 2, int'($urandom_range(0, 3)));
        end

        @(negedge clk);
        bus.instr_valid = 1'b0;
        sample("final_fetch", mk(1'b1, 6'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
